// File: rtl/alu_uart_interface_if.sv
// alu_uart_interface_if: byte and control bundle between a UART receiver /
// transmitter pair, an external combinational ALU, and the sequencer that
// feeds the ALU from received bytes and sends its result back.
//   rx_data/rx_done : byte from the UART receiver, rx_done is a 1-cycle pulse
//   tx_done         : 1-cycle pulse, transmitter finished the current byte
//   alu_result      : combinational ALU output
//   dato_A/dato_B/op: registered operands and operator code to the ALU
//   tx_data/tx_start: registered byte and 1-cycle start request to the transmitter
//   busy/overrun    : sequencer status
// master = environment (UART + ALU), slave = sequencer.
interface alu_uart_interface_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OP_WIDTH   = 6
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_done;
  logic                  tx_done;
  logic [DATA_WIDTH-1:0] alu_result;
  logic [DATA_WIDTH-1:0] dato_A;
  logic [DATA_WIDTH-1:0] dato_B;
  logic [OP_WIDTH-1:0]   op;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_start;
  logic                  busy;
  logic                  overrun;

  modport master (
    output rx_data, rx_done, tx_done, alu_result,
    input  dato_A, dato_B, op, tx_data, tx_start, busy, overrun
  );

  modport slave (
    input  rx_data, rx_done, tx_done, alu_result,
    output dato_A, dato_B, op, tx_data, tx_start, busy, overrun
  );
endinterface

// File: rtl/alu_uart_interface.sv
// alu_uart_interface: collects operand A, operand B and an operator byte from
// the UART receiver, presents them to an external ALU, captures the ALU result
// one cycle later and hands it to the UART transmitter, then waits for the
// transmitter to finish before accepting the next operand A.
// Ports:
//   clock   : single clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : alu_uart_interface_if.slave (see interface for signal list)
module alu_uart_interface #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OP_WIDTH   = 6
) (
  input  logic                  clock,
  input  logic                  reset_n,
  alu_uart_interface_if.slave   bus
);

  // One-hot so tx_start/busy are plain decodes of state flops.
  typedef enum logic [5:0] {
    WAIT_A  = 6'b000001,
    WAIT_B  = 6'b000010,
    WAIT_OP = 6'b000100,
    COMPUTE = 6'b001000,
    SEND    = 6'b010000,
    WAIT_TX = 6'b100000
  } state_e;

  state_e                state_q,   state_d;
  logic [DATA_WIDTH-1:0] dato_a_q,  dato_a_d;
  logic [DATA_WIDTH-1:0] dato_b_q,  dato_b_d;
  logic [OP_WIDTH-1:0]   op_q,      op_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  overrun_q, overrun_d;
  logic                  busy_s;

  assign busy_s = (state_q == COMPUTE) || (state_q == SEND) || (state_q == WAIT_TX);

  always_comb begin
    state_d   = state_q;
    dato_a_d  = dato_a_q;
    dato_b_d  = dato_b_q;
    op_d      = op_q;
    tx_data_d = tx_data_q;
    // A byte arriving while busy is dropped; only the sticky flag records it.
    overrun_d = overrun_q | (bus.rx_done & busy_s);

    unique case (state_q)
      WAIT_A: begin
        if (bus.rx_done) begin
          dato_a_d = bus.rx_data;
          state_d  = WAIT_B;
        end
      end
      WAIT_B: begin
        if (bus.rx_done) begin
          dato_b_d = bus.rx_data;
          state_d  = WAIT_OP;
        end
      end
      WAIT_OP: begin
        if (bus.rx_done) begin
          op_d    = bus.rx_data[OP_WIDTH-1:0];
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        // ALU inputs have been stable for one full cycle here.
        tx_data_d = bus.alu_result;
        state_d   = SEND;
      end
      SEND: begin
        state_d = WAIT_TX;
      end
      WAIT_TX: begin
        if (bus.tx_done) begin
          state_d = WAIT_A;
        end
      end
      default: begin
        state_d = WAIT_A;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= WAIT_A;
      dato_a_q  <= '0;
      dato_b_q  <= '0;
      op_q      <= '0;
      tx_data_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dato_a_q  <= dato_a_d;
      dato_b_q  <= dato_b_d;
      op_q      <= op_d;
      tx_data_q <= tx_data_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.dato_A   = dato_a_q;
  assign bus.dato_B   = dato_b_q;
  assign bus.op       = op_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = (state_q == SEND);
  assign bus.busy     = busy_s;
  assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_alu_uart_interface.sv
module tb_alu_uart_interface;

  logic clock;
  logic reset_n;

  alu_uart_interface_if #(.DATA_WIDTH(8), .OP_WIDTH(6)) ifc ();

  // ALU model: 8-bit wrapping add.
  assign ifc.alu_result = ifc.dato_A + ifc.dato_B;

  alu_uart_interface #(.DATA_WIDTH(8), .OP_WIDTH(6)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (ifc.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned tests_run;
  int unsigned fail_cnt;
  int unsigned tx_start_cnt;
  logic [7:0]  sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every tx_start pops one expected byte.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clock);
      if (ifc.tx_start === 1'b1) begin
        tx_start_cnt++;
        check("sb_pending", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("sb_tx_data", 32'(ifc.tx_data), 32'(e));
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    ifc.rx_data = b;
    ifc.rx_done = 1'b1;
    @(negedge clock);
    ifc.rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    @(negedge clock);
    ifc.tx_done = 1'b1;
    @(negedge clock);
    ifc.tx_done = 1'b0;
  endtask

  // Sends the op byte from WAIT_OP, checks the latency, leaves DUT in WAIT_TX.
  task automatic op_phase(input logic [7:0] o, input logic [7:0] exp_res);
    int unsigned cnt0;
    cnt0 = tx_start_cnt;
    sb.push_back(exp_res);
    send_byte(o);
    check("op_captured", 32'(ifc.op), 32'(o[5:0]));
    check("compute_busy", 32'(ifc.busy), 32'd1);
    check("compute_no_start", 32'(ifc.tx_start), 32'd0);
    @(negedge clock);
    check("send_start", 32'(ifc.tx_start), 32'd1);
    check("send_tx_data", 32'(ifc.tx_data), 32'(exp_res));
    @(negedge clock);
    check("waittx_start_low", 32'(ifc.tx_start), 32'd0);
    check("one_start_pulse", tx_start_cnt, cnt0 + 1);
    check("waittx_busy", 32'(ifc.busy), 32'd1);
  endtask

  task automatic do_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] o);
    send_byte(a);
    check("a_captured", 32'(ifc.dato_A), 32'(a));
    send_byte(b);
    check("b_captured", 32'(ifc.dato_B), 32'(b));
    check("idle_not_busy", 32'(ifc.busy), 32'd0);
    op_phase(o, a + b);
  endtask

  initial begin
    int unsigned cnt_snap;
    tests_run    = 0;
    fail_cnt     = 0;
    tx_start_cnt = 0;
    reset_n      = 1'b0;
    ifc.rx_data  = '0;
    ifc.rx_done  = 1'b0;
    ifc.tx_done  = 1'b0;

    #2;
    check("rst_dato_A", 32'(ifc.dato_A), 32'd0);
    check("rst_tx_start", 32'(ifc.tx_start), 32'd0);
    check("rst_busy", 32'(ifc.busy), 32'd0);
    check("rst_overrun", 32'(ifc.overrun), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // Basic transaction.
    do_txn(8'h05, 8'h03, 8'h20);
    pulse_tx_done();
    check("t1_idle", 32'(ifc.busy), 32'd0);

    // Wrap-around and op truncation.
    do_txn(8'hF0, 8'h20, 8'hFF);
    check("t2_overrun_clear", 32'(ifc.overrun), 32'd0);

    // Byte during WAIT_TX is dropped.
    send_byte(8'h11);
    check("t3_a_kept", 32'(ifc.dato_A), 32'hF0);
    check("t3_b_kept", 32'(ifc.dato_B), 32'h20);
    check("t3_op_kept", 32'(ifc.op), 32'h3F);
    check("t3_still_busy", 32'(ifc.busy), 32'd1);
    check("t3_overrun", 32'(ifc.overrun), 32'd1);
    pulse_tx_done();
    check("t3_idle", 32'(ifc.busy), 32'd0);
    do_txn(8'h01, 8'h02, 8'h03);
    pulse_tx_done();
    check("t3_overrun_sticky", 32'(ifc.overrun), 32'd1);

    // Asynchronous reset in WAIT_OP.
    send_byte(8'h07);
    send_byte(8'h01);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_dato_A", 32'(ifc.dato_A), 32'd0);
    check("arst_dato_B", 32'(ifc.dato_B), 32'd0);
    check("arst_op", 32'(ifc.op), 32'd0);
    check("arst_tx_data", 32'(ifc.tx_data), 32'd0);
    check("arst_overrun", 32'(ifc.overrun), 32'd0);
    check("arst_busy", 32'(ifc.busy), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    cnt_snap = tx_start_cnt;
    send_byte(8'h09);
    repeat (4) @(negedge clock);
    check("arst_no_start", tx_start_cnt, cnt_snap);
    check("arst_new_a", 32'(ifc.dato_A), 32'h09);
    check("arst_idle", 32'(ifc.busy), 32'd0);

    // Complete the transaction, then rx_done and tx_done together in WAIT_TX.
    send_byte(8'h02);
    op_phase(8'h00, 8'h0B);
    @(negedge clock);
    ifc.rx_data = 8'h55;
    ifc.rx_done = 1'b1;
    ifc.tx_done = 1'b1;
    @(negedge clock);
    ifc.rx_done = 1'b0;
    ifc.tx_done = 1'b0;
    check("both_idle", 32'(ifc.busy), 32'd0);
    check("both_a_kept", 32'(ifc.dato_A), 32'h09);
    check("both_overrun", 32'(ifc.overrun), 32'd1);

    // tx_done in WAIT_A is ignored.
    cnt_snap = tx_start_cnt;
    pulse_tx_done();
    check("txd_idle", 32'(ifc.busy), 32'd0);
    check("txd_tx_data", 32'(ifc.tx_data), 32'h0B);
    send_byte(8'h04);
    check("txd_still_wait_a", 32'(ifc.dato_A), 32'h04);
    check("txd_b_kept", 32'(ifc.dato_B), 32'h02);
    repeat (2) @(negedge clock);
    check("txd_no_start", tx_start_cnt, cnt_snap);

    check("sb_drained", 32'(sb.size()), 32'd0);
    check("total_starts", tx_start_cnt, 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
